// File: rtl/pipelined_addsub.sv
// pipelined_addsub: WIDTH-bit adder/subtractor, carry chain split into STAGES registered segments
// Ports: clk, rst (synchronous, active-high)
//        in_valid/in_ready, inputA, inputB, sub (0 = A+B, 1 = A-B) : operand handshake
//        out_valid/out_ready, p_0[WIDTH:0]                      : result handshake, p_0[WIDTH] = carry-out
// Optional: define PIPELINED_ADDSUB_OVF_EN to add ovf, the signed overflow flag registered with p_0.
module pipelined_addsub #(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] inputA,
    input  logic [WIDTH-1:0] inputB,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH:0]   p_0
`ifdef PIPELINED_ADDSUB_OVF_EN
    ,
    output logic             ovf
`endif
);
    localparam int SEG = WIDTH / STAGES;

    logic [WIDTH-1:0] a_q   [STAGES];
    logic [WIDTH-1:0] b_q   [STAGES];
    logic [WIDTH-1:0] sum_q [STAGES];
    logic             cy_q  [STAGES];
    logic             vld_q [STAGES];
    logic             stall;

    // The whole pipe freezes on a blocked output; bubbles are kept, not collapsed.
    assign stall     = vld_q[STAGES-1] && !out_ready;
    assign in_ready  = !stall;
    assign out_valid = vld_q[STAGES-1];
    assign p_0       = {cy_q[STAGES-1], sum_q[STAGES-1]};

    for (genvar s = 0; s < STAGES; s++) begin : g_stage
        logic [WIDTH-1:0] a_i, b_i, sum_i, a_d, b_d, sum_d;
        logic             cy_i, vld_i, cy_d, vld_d;
        logic [SEG:0]     seg;
        if (s == 0) begin : g_in
            // Subtraction is A + ~B + 1: invert B and feed sub as the carry-in.
            assign a_i   = inputA;
            assign b_i   = inputB ^ {WIDTH{sub}};
            assign sum_i = '0;
            assign cy_i  = sub;
            assign vld_i = in_valid;
        end else begin : g_in
            assign a_i   = a_q[s-1];
            assign b_i   = b_q[s-1];
            assign sum_i = sum_q[s-1];
            assign cy_i  = cy_q[s-1];
            assign vld_i = vld_q[s-1];
        end
        always_comb begin
            seg                 = {1'b0, a_i[s*SEG +: SEG]} + {1'b0, b_i[s*SEG +: SEG]} + {{SEG{1'b0}}, cy_i};
            sum_d               = sum_i;
            sum_d[s*SEG +: SEG] = seg[SEG-1:0];
            cy_d                = seg[SEG];
            a_d                 = a_i;
            b_d                 = b_i;
            vld_d               = vld_i;
        end
        always_ff @(posedge clk) begin
            if (rst) begin
                vld_q[s] <= 1'b0;
                cy_q[s]  <= 1'b0;
                sum_q[s] <= '0;
            end else if (!stall) begin
                vld_q[s] <= vld_d;
                cy_q[s]  <= cy_d;
                sum_q[s] <= sum_d;
                a_q[s]   <= a_d;
                b_q[s]   <= b_d;
            end
        end
`ifdef PIPELINED_ADDSUB_OVF_EN
        if (s == STAGES - 1) begin : g_ovf
            logic ovf_d, ovf_q;
            // Carry into the MSB is recovered from the MSB sum bit and its two operand bits.
            always_comb ovf_d = cy_d ^ a_i[WIDTH-1] ^ b_i[WIDTH-1] ^ sum_d[WIDTH-1];
            always_ff @(posedge clk) begin
                if (rst)         ovf_q <= 1'b0;
                else if (!stall) ovf_q <= ovf_d;
            end
            assign ovf = ovf_q;
        end
`endif
    end
endmodule

// File: tb/tb_pipelined_addsub.sv
// tb_pipelined_addsub: self-checking bench for pipelined_addsub at 8/2, 16/4 and 8/1
module tb_pipelined_addsub;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic       iv0 = 1'b0, s0 = 1'b0, or0 = 1'b1, ir0, ov0;
    logic [7:0] a0 = '0, b0 = '0;
    logic [8:0] p0;
    logic        iv1 = 1'b0, s1 = 1'b0, or1 = 1'b1, ir1, ov1;
    logic [15:0] a1 = '0, b1 = '0;
    logic [16:0] p1;
    logic       iv2 = 1'b0, s2 = 1'b0, or2 = 1'b1, ir2, ov2;
    logic [7:0] a2 = '0, b2 = '0;
    logic [8:0] p2;
`ifdef PIPELINED_ADDSUB_OVF_EN
    logic f0, f1, f2;
`endif

    logic [16:0] q1 [$];
    logic [16:0] q2 [$];
    int          n1 = 0, n2 = 0;
    logic        hold1 = 1'b0, hold2 = 1'b0, stl1 = 1'b0, stl2 = 1'b0;
    logic [16:0] held1 = '0, held2 = '0;

    pipelined_addsub #(.WIDTH(8), .STAGES(2)) dut0 (
        .clk(clk), .rst(rst), .in_valid(iv0), .in_ready(ir0), .inputA(a0), .inputB(b0), .sub(s0),
        .out_valid(ov0), .out_ready(or0), .p_0(p0)
`ifdef PIPELINED_ADDSUB_OVF_EN
        , .ovf(f0)
`endif
    );
    pipelined_addsub #(.WIDTH(16), .STAGES(4)) dut1 (
        .clk(clk), .rst(rst), .in_valid(iv1), .in_ready(ir1), .inputA(a1), .inputB(b1), .sub(s1),
        .out_valid(ov1), .out_ready(or1), .p_0(p1)
`ifdef PIPELINED_ADDSUB_OVF_EN
        , .ovf(f1)
`endif
    );
    pipelined_addsub #(.WIDTH(8), .STAGES(1)) dut2 (
        .clk(clk), .rst(rst), .in_valid(iv2), .in_ready(ir2), .inputA(a2), .inputB(b2), .sub(s2),
        .out_valid(ov2), .out_ready(or2), .p_0(p2)
`ifdef PIPELINED_ADDSUB_OVF_EN
        , .ovf(f2)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: A+B, or A-B offset by 2^w so bit w reads as "no borrow"; all modulo 2^(w+1).
    function automatic logic [16:0] model(input int w, input logic [15:0] a, input logic [15:0] b, input logic s);
        longint unsigned m, x, y, r;
        m = 64'd1 << w;
        x = 64'(a) % m;
        y = 64'(b) % m;
        r = s ? x + m - y : x + y;
        return 17'(r % (m << 1));
    endfunction

    // Single operation on dut0 with out_ready high; called just after a falling edge.
    task automatic op0(input string tag, input logic [7:0] a, input logic [7:0] b, input logic s,
                       input logic [8:0] exp, input logic ef);
        iv0 = 1'b1; a0 = a; b0 = b; s0 = s;
        @(negedge clk);
        iv0 = 1'b0;
        #1;
        check({tag, "_early"}, 32'(ov0), 32'd0);
        @(negedge clk);
        #1;
        check({tag, "_valid"}, 32'(ov0), 32'd1);
        check(tag, 32'(p0), 32'(exp));
`ifdef PIPELINED_ADDSUB_OVF_EN
        check({tag, "_ovf"}, 32'(f0), 32'(ef));
`else
        if (ef) check({tag, "_ovf_off"}, 32'(ov0), 32'd1);
`endif
        @(negedge clk);
    endtask

    // Stream 0x10+1, 0x20+2, 0x30+3 into dut0 with out_ready low for len cycles from cycle st.
    task automatic stream0(input string tag, input int st, input int len);
        logic [8:0] exp_r [3];
        int         nxt, got;
        logic       acc;
        exp_r[0] = 9'h011; exp_r[1] = 9'h022; exp_r[2] = 9'h033;
        nxt = 0;
        got = 0;
        for (int i = 0; i < 10; i++) begin
            iv0 = nxt < 3;
            a0  = 8'(16 * (nxt + 1));
            b0  = 8'(nxt + 1);
            s0  = 1'b0;
            or0 = !(i >= st && i < st + len);
            #1;
            if (ov0 && !or0) begin
                check({tag, "_stall_ready"}, 32'(ir0), 32'd0);
                check({tag, "_stall_hold"}, 32'(p0), 32'h011);
            end else begin
                check({tag, "_ready"}, 32'(ir0), 32'd1);
            end
            if (ov0 && or0) begin
                if (got < 3) begin
                    check({tag, "_res"}, 32'(p0), 32'(exp_r[got]));
                    check({tag, "_cycle"}, 32'(i), 32'(got + 2 + len));
                end else begin
                    check({tag, "_extra"}, 32'(ov0), 32'd0);
                end
                got++;
            end
            acc = iv0 && ir0;
            @(negedge clk);
            if (acc) nxt++;
        end
        iv0 = 1'b0;
        or0 = 1'b1;
        check({tag, "_count"}, 32'(got), 32'd3);
    endtask

    initial begin
        int l1, l2;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_out_valid", 32'(ov0), 32'd0);
        check("rst_p0", 32'(p0), 32'd0);
        check("rst_in_ready", 32'(ir0), 32'd1);
`ifdef PIPELINED_ADDSUB_OVF_EN
        check("rst_ovf", 32'(f0), 32'd0);
`endif
        op0("add_carry", 8'hFF, 8'h01, 1'b0, 9'h100, 1'b0);
        op0("sub_borrow", 8'h05, 8'h07, 1'b1, 9'h0FE, 1'b0);
        op0("sub_noborrow", 8'h07, 8'h05, 1'b1, 9'h102, 1'b0);
        stream0("b2b", 100, 0);
        stream0("bp", 2, 3);

        iv0 = 1'b1; a0 = 8'h7F; b0 = 8'h01; s0 = 1'b0;
        @(negedge clk);
        iv0 = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("mid_rst_valid", 32'(ov0), 32'd0);
        check("mid_rst_p0", 32'(p0), 32'd0);
        repeat (4) begin
            @(negedge clk);
            #1;
            check("mid_rst_stale", 32'(ov0), 32'd0);
        end
        op0("ovf_add", 8'h7F, 8'h01, 1'b0, 9'h080, 1'b1);

        iv1 = 1'b1; a1 = 16'h1234; b1 = 16'h0FFF; s1 = 1'b1;
        iv2 = 1'b1; a2 = 8'hC0;    b2 = 8'h50;    s2 = 1'b0;
        l1 = 0;
        l2 = 0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            iv1 = 1'b0;
            iv2 = 1'b0;
            #1;
            if (ov1 && l1 == 0) begin
                l1 = k;
                check("lat16_res", 32'(p1), 32'(model(16, 16'h1234, 16'h0FFF, 1'b1)));
            end
            if (ov2 && l2 == 0) begin
                l2 = k;
                check("lat8s1_res", 32'(p2), 32'(model(8, 16'h00C0, 16'h0050, 1'b0)));
            end
        end
        check("lat16", 32'(l1), 32'd4);
        check("lat8s1", 32'(l2), 32'd1);

        for (int cyc = 0; cyc < 8000 && (n1 < 1000 || n2 < 1000 || q1.size() != 0 || q2.size() != 0); cyc++) begin
            if (!hold1) begin
                iv1 = n1 < 1000 && $urandom_range(0, 3) != 0;
                a1  = 16'($urandom);
                b1  = 16'($urandom);
                s1  = 1'($urandom);
            end
            if (!hold2) begin
                iv2 = n2 < 1000 && $urandom_range(0, 3) != 0;
                a2  = 8'($urandom);
                b2  = 8'($urandom);
                s2  = 1'($urandom);
            end
            or1 = $urandom_range(0, 3) != 0;
            or2 = $urandom_range(0, 3) != 0;
            #1;
            if (stl1) begin
                check("hold16_valid", 32'(ov1), 32'd1);
                check("hold16_p", 32'(p1), 32'(held1));
            end
            if (stl2) begin
                check("hold8s1_valid", 32'(ov2), 32'd1);
                check("hold8s1_p", 32'(p2), 32'(held2));
            end
            stl1  = ov1 && !or1;
            stl2  = ov2 && !or2;
            held1 = p1;
            held2 = {8'h00, p2};
            if (ov1 && or1) begin
                if (q1.size() == 0) check("spurious16", 32'(ov1), 32'd0);
                else                check("res16", 32'(p1), 32'(q1.pop_front()));
            end
            if (ov2 && or2) begin
                if (q2.size() == 0) check("spurious8s1", 32'(ov2), 32'd0);
                else                check("res8s1", 32'(p2), 32'(q2.pop_front()));
            end
            if (iv1 && ir1) begin
                q1.push_back(model(16, a1, b1, s1));
                n1++;
            end
            if (iv2 && ir2) begin
                q2.push_back(model(8, {8'h00, a2}, {8'h00, b2}, s2));
                n2++;
            end
            hold1 = iv1 && !ir1;
            hold2 = iv2 && !ir2;
            @(negedge clk);
        end
        check("drain16", 32'(q1.size()), 32'd0);
        check("drain8s1", 32'(q2.size()), 32'd0);
        check("count16", 32'(n1), 32'd1000);
        check("count8s1", 32'(n2), 32'd1000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/pipelined_addsub.md
Name: pipelined_addsub

Overview:
- Parametrised, pipelined successor to the team's 8-bit combinational adder datapath. It computes A+B or A−B at any WIDTH.
- The ripple carry chain is split into STAGES registered segments, so throughput is one operation per clock with a latency of STAGES cycles.
- Valid/ready handshakes on both sides allow the block to sit between buffered producers and consumers in the arithmetic datapath.

Parameters:
- WIDTH, 8: operand width in bits. Result is WIDTH+1 bits.
- STAGES, 2: number of pipeline segments. Must satisfy 1 ≤ STAGES ≤ WIDTH and WIDTH % STAGES == 0. Segment width SEG = WIDTH/STAGES.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- in_valid  in  1  operand pair and mode are valid.
- in_ready  out  1  block can accept operands this cycle.
- inputA  in  WIDTH  operand A, unsigned or two's complement.
- inputB  in  WIDTH  operand B.
- sub  in  1  0 = A+B; 1 = A−B.
- out_valid  out  1  p_0 holds a valid result.
- out_ready  in  1  consumer accepts the result this cycle.
- p_0  out  WIDTH+1  result. Bit WIDTH is the carry-out; for subtraction, 1 means no borrow.

Behaviour:
- Reset (rst high at an edge): all stage valid bits clear. out_valid=0 and p_0=0. in_ready becomes 1 in the cycle after reset. Data registers other than p_0 are don't-care. Reset mid-operation discards all in-flight operations; no partial result is ever presented.
- Input transfer occurs on an edge where in_valid && in_ready. Output transfer occurs on an edge where out_valid && out_ready.
- Stall rule:
  - stall = out_valid && !out_ready.
  - in_ready = !stall (combinational).
  - During a stall every stage register freezes, including p_0 and out_valid.
  - Bubbles are not collapsed.
- Arithmetic:
  - Effective B is inputB ^ {WIDTH{sub}}; carry-in is sub.
  - Stage s (0-based) adds operand bits [s*SEG +: SEG] plus the carry registered by stage s−1 (stage 0 uses the carry-in).
  - Stage s registers the following, together with its valid bit:
    - the cumulative sum bits [0 .. (s+1)*SEG−1];
    - the carry-out;
    - the still-unconsumed upper operand bits.
  - The final stage drives p_0 = {carry, sum} and out_valid.
- Latency: an operation accepted at edge E appears on p_0/out_valid after edge E+STAGES−1, provided there are no stalls. STAGES=1 gives a single registered output.
- Throughput: one result per cycle while out_ready=1.
- Ordering: results leave in acceptance order. No drop or duplication under any in_valid/out_ready pattern.
- Simultaneous events:
  - With out_ready=1 and in_valid=1, accept and output happen on the same edge.
  - in_valid=1 while in_ready=0 is ignored; the producer must hold.
- Wrap-around: the sum is modulo 2^WIDTH. Overflow is reported only through p_0[WIDTH], plus ovf when the optional feature is enabled.
- Once out_valid is asserted, p_0 stays stable until the output transfer edge.

Optional Feature:
- Macro PIPELINED_ADDSUB_OVF_EN.
- When defined:
  - Adds output port ovf (1 bit), pipelined alongside p_0 and held under stall.
  - ovf=1 when the signed two's-complement result overflows, i.e. carry into the MSB differs from carry out of the MSB.
  - Reset value is 0.
- When undefined: no ovf port and no extra registers; all other behaviour is identical.

Test Plan (WIDTH=8, STAGES=2 unless stated):
- Add carry across segments: A=0xFF, B=0x01, sub=0, out_ready=1 → p_0=0x100 with out_valid exactly 2 cycles after acceptance. With OVF_EN, ovf=0.
- Subtract with borrow: A=0x05, B=0x07, sub=1 → p_0=0x0FE. Then A=0x07, B=0x05, sub=1 → p_0=0x102.
- Back-to-back stream: 0x10+0x01, 0x20+0x02, 0x30+0x03 with out_ready=1 → results 0x011, 0x022, 0x033 on consecutive cycles, in_ready never drops.
- Backpressure: same stream, out_ready=0 from the first out_valid for 3 cycles → in_ready=0 during the stall, p_0 holds 0x011, then 0x011, 0x022, 0x033 emerge in order with no loss.
- Reset mid-flight: accept 0x7F+0x01, assert rst the next cycle → out_valid=0 and p_0=0x000 after reset, no stale result ever emitted. With OVF_EN and no reset, 0x7F+0x01 gives ovf=1.
- Parameter sweep: WIDTH=16/STAGES=4 and WIDTH=8/STAGES=1, 1000 random operands with random in_valid/out_ready → all results match a reference model (A±B modulo 2^(WIDTH+1) semantics), order preserved, latency=STAGES.
